// File: rtl/codec_i2c_responder_pkg.sv
// Shared configuration for the WM8731 control-port responder:
// FSM state encoding, device address and codec register map.
package codec_cfg_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ACK_A,
        REG,
        ACK_R,
        DATA,
        ACK_D,
        WAIT_STOP,
        IGNORE
    } state_t;

    localparam logic [6:0] WM8731_DEV_ADDR = 7'h1A;

    // WM8731 register addresses
    localparam logic [6:0] WM_R_LLINEIN  = 7'h00;
    localparam logic [6:0] WM_R_RLINEIN  = 7'h01;
    localparam logic [6:0] WM_R_LHPOUT   = 7'h02;
    localparam logic [6:0] WM_R_RHPOUT   = 7'h03;
    localparam logic [6:0] WM_R_APANA    = 7'h04;
    localparam logic [6:0] WM_R_DPATH    = 7'h05;
    localparam logic [6:0] WM_R_PDOWN    = 7'h06;
    localparam logic [6:0] WM_R_DAIF     = 7'h07;
    localparam logic [6:0] WM_R_SAMPLING = 7'h08;
    localparam logic [6:0] WM_R_ACTIVE   = 7'h09;
    localparam logic [6:0] WM_R_RESET    = 7'h0F;

endpackage

// File: rtl/codec_i2c_responder_if.sv
// I2C bus lines and decoded register-write outputs of the codec responder.
interface codec_i2c_responder_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       reg_wr_valid;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
    logic       frame_err;
    logic       busy;

    modport slave (
        input  scl_in, sda_in,
        output sda_oe, reg_wr_valid, reg_addr, reg_data, frame_err, busy
    );

    modport master (
        output scl_in, sda_in,
        input  sda_oe, reg_wr_valid, reg_addr, reg_data, frame_err, busy
    );
endinterface

// File: rtl/codec_i2c_responder_line_cond.sv
// Per-line conditioner: synchronizer, optional 3-sample stability filter
// (CODEC_I2C_GLITCH_FILTER_EN) and rise/fall detection.
module i2c_line_cond #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   hist_q;

    // Synchronizer chain plus history flop; idle bus level is high
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
            hist_q <= level;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef CODEC_I2C_GLITCH_FILTER_EN
    logic [1:0] samp_q;

    // Two previous synchronizer samples for the stability check
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            samp_q <= '1;
        end else begin
            samp_q <= {samp_q[0], sync_out};
        end
    end

    // hist_q doubles as the filtered level: a new value is accepted only
    // once three consecutive samples agree
    always_comb begin
        level = hist_q;
        if (sync_out == samp_q[0] && sync_out == samp_q[1]) begin
            level = sync_out;
        end
    end
`else
    assign level = sync_out;
`endif

    assign rise = level & ~hist_q;
    assign fall = ~level & hist_q;

endmodule

// File: rtl/codec_i2c_responder.sv
// WM8731 control-port I2C responder: decodes 3-byte writes into a 7-bit
// register address and 9-bit value. Optional glitch filter on both lines
// is enabled with CODEC_I2C_GLITCH_FILTER_EN.
module codec_i2c_responder
    import codec_cfg_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = WM8731_DEV_ADDR,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    codec_i2c_responder_if.slave bus
);
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic [7:0] rx_byte;
    logic [6:0] addr_q;
    logic       data_msb_q;
    logic [7:0] data_lo_q;
    logic       sda_oe_q;
    logic       wr_valid_q;
    logic       frame_err_q;
    logic [6:0] reg_addr_q;
    logic [8:0] reg_data_q;

    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .clock   (clock),
        .reset_n (reset_n),
        .line_in (bus.scl_in),
        .level   (scl_lvl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clock   (clock),
        .reset_n (reset_n),
        .line_in (bus.sda_in),
        .level   (sda_lvl),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign rx_byte   = {shift_q, sda_lvl};

    // Frame FSM with shift register, ACK drive and commit registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            data_msb_q  <= 1'b0;
            data_lo_q   <= '0;
            sda_oe_q    <= 1'b0;
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_data_q  <= '0;
        end else begin
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (start_det || stop_det) begin
                // A repeated START after a complete frame also commits it
                case (state_q)
                    ADDR, ACK_A, REG, ACK_R, DATA, ACK_D: frame_err_q <= 1'b1;
                    WAIT_STOP: begin
                        reg_addr_q <= addr_q;
                        reg_data_q <= {data_msb_q, data_lo_q};
                        wr_valid_q <= 1'b1;
                    end
                    default: ;
                endcase
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= start_det ? ADDR : IDLE;
            end else begin
                case (state_q)
                    ADDR, REG, DATA: begin
                        if (scl_rise) begin
                            shift_q   <= rx_byte[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                case (state_q)
                                    ADDR: begin
                                        if (rx_byte == {DEV_ADDR, 1'b0}) begin
                                            state_q <= ACK_A;
                                        end else begin
                                            state_q     <= IGNORE;
                                            frame_err_q <= 1'b1;
                                        end
                                    end
                                    REG: begin
                                        addr_q     <= rx_byte[7:1];
                                        data_msb_q <= rx_byte[0];
                                        state_q    <= ACK_R;
                                    end
                                    default: begin
                                        data_lo_q <= rx_byte;
                                        state_q   <= ACK_D;
                                    end
                                endcase
                            end
                        end
                    end
                    // First SCL fall after the 8th bit drives ACK, the next releases it
                    ACK_A, ACK_R, ACK_D: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                sda_oe_q <= 1'b0;
                                case (state_q)
                                    ACK_A:   state_q <= REG;
                                    ACK_R:   state_q <= DATA;
                                    default: state_q <= WAIT_STOP;
                                endcase
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.sda_oe       = sda_oe_q;
    assign bus.reg_wr_valid = wr_valid_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.reg_addr     = reg_addr_q;
    assign bus.reg_data     = reg_data_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: doc/codec_i2c_responder.md
# codec_i2c_responder

Synchronous I2C slave model of the WM8731 audio codec's control port: the receiving end of the 24-bit configuration frames the `i2c` master sends to the codec. It oversamples SCL/SDA on the system clock, detects START/STOP, acknowledges the device address, and decodes each 3-byte write into a 7-bit register address and 9-bit register value. It serves as the codec-side model in system-level benches and as an on-FPGA monitor of the configuration actually sent by `CLOCK_500`.

## Interface
Parameters:
- `DEV_ADDR`, 7'h1A: 7-bit device address (WM8731, CSB low; write byte 0x34).
- `SYNC_STAGES`, 2: synchronizer depth on `scl_in`/`sda_in`; minimum 2.

Ports:
- `clock` in 1: system clock (CLOCK_50 domain); one clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `scl_in` in 1: I2C clock from the bus (asynchronous).
- `sda_in` in 1: I2C data from the bus (asynchronous).
- `sda_oe` out 1: 1 = pull SDA low (ACK); top level ties the pad to `sda_oe ? 1'b0 : 1'bz`.
- `reg_wr_valid` out 1: one-cycle pulse; a complete write frame was committed.
- `reg_addr` out 7: register address of the last committed write.
- `reg_data` out 9: register value of the last committed write.
- `frame_err` out 1: one-cycle pulse; frame aborted (STOP/START mid-frame, or NACKed address).
- `busy` out 1: high from START until return to IDLE.

## Operation
- Inputs pass through `SYNC_STAGES` flops, then one history flop for edge detection.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are recognised in every state.
- Bits are sampled on SCL rising, MSB first; 3-bit bit counter, 8-bit shift register.
- States: IDLE, ADDR, ACK_A, REG, ACK_R, DATA, ACK_D, WAIT_STOP, IGNORE.
  - IDLE -> ADDR on START.
  - ADDR -> ACK_A after 8 bits if byte == {DEV_ADDR,1'b0}; otherwise -> IGNORE, `frame_err` pulse, no ACK.
  - ACK_A -> REG; REG captures {addr[6:0], data[8]}; -> ACK_R.
  - ACK_R -> DATA; DATA captures data[7:0]; -> ACK_D; ACK_D -> WAIT_STOP.
  - WAIT_STOP: STOP -> commit and IDLE. Further bits are ignored and not ACKed.
  - IGNORE: waits for STOP (-> IDLE) or START (-> ADDR).
- ACK: `sda_oe` rises on the SCL falling edge following the 8th bit and falls on the next SCL falling edge.
- Commit: `reg_addr`/`reg_data` update and `reg_wr_valid` pulses together. The outputs hold until the next commit.
- STOP or START in ADDR..ACK_D: `frame_err` pulse, nothing committed, `sda_oe` released immediately. START re-enters ADDR.
- R/W bit = 1 (read) is treated as an address mismatch.

## Timing
- Reset values: `sda_oe`=0, `reg_wr_valid`=0, `frame_err`=0, `busy`=0, `reg_addr`=0, `reg_data`=0, state IDLE.
- Pin-to-detect latency is `SYNC_STAGES`+1 cycles. `reg_wr_valid` asserts the cycle after STOP detection.
- `sda_oe` changes 1 cycle after the detected SCL falling edge. SCL low time must exceed `SYNC_STAGES`+3 clock cycles (trivially met with a 1 MHz-derived SCL).
- `reset_n` asserted mid-frame: immediate IDLE, `sda_oe` released in the same instant, no commit, no `frame_err`.
- `reg_wr_valid` and `frame_err` are never high in the same cycle.

## Configuration
- `CODEC_I2C_GLITCH_FILTER_EN`, when defined: after the synchronizer, each line passes a 3-sample majority/stability filter. A level change is accepted only after 3 consecutive equal samples, adding 2 cycles of latency to every detect. Spikes of 2 cycles or less are rejected.
- When undefined: synchronizer output feeds edge detection directly. A 1-cycle spike on SDA while SCL is high is treated as START/STOP.

## Structure
- Package `codec_cfg_pkg`:
  - state enum;
  - `WM8731_DEV_ADDR` = 7'h1A;
  - WM8731 register address constants (R0 LLINEIN … R9 ACTIVE, R15 RESET).
- Sub-module `i2c_line_cond`, instantiated once per line. It holds the synchronizer, the optional glitch filter, and the rise/fall outputs. The FSM and shift/ACK logic stay in the top module.

## Test plan
- Frame 0x34, 0x00, 0x17 + STOP -> three ACKs; `reg_wr_valid` pulse once; `reg_addr`=7'h00, `reg_data`=9'h017.
- Frame 0x34, 0x05, 0x79 + STOP -> `reg_addr`=7'h02, `reg_data`=9'h179.
- Address byte 0x36 -> no ACK (`sda_oe` stays 0); `frame_err` pulse; no commit; `busy` drops at STOP.
- 0x34, 0x0C, then STOP after 4 data bits -> `frame_err` pulse; `reg_addr`/`reg_data` keep their previous values.
- Repeated START after the register byte, then a full 0x34, 0x12, 0x01 + STOP -> one `frame_err`, then commit of `reg_addr`=7'h09, `reg_data`=9'h001.
- `reset_n` low during DATA while `sda_oe`=1 -> `sda_oe`=0 at once; all outputs at reset values; the next full frame commits normally.
- With `CODEC_I2C_GLITCH_FILTER_EN` defined: a 1-cycle SDA low pulse while SCL is high -> no START detected, `busy` stays 0.
